// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder: receiving end of an HD44780-style 8-bit LCD write bus.
// Decodes commands and character writes into a 2x16 display RAM mirror,
// runs a blanking clear engine, and offers a registered readback port.
// Optional feature macro: LCD_SHIFT_EN enables the display/cursor shift command.
module lcd_bus_decoder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs,
    input  logic       e,
    input  logic [7:0] data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [4:0] cursor,
    output logic       display_on,
    output logic       busy,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       char_valid,
    output logic       overrun,
    output logic [3:0] disp_shift
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    logic [SYNC_STAGES-1:0]      eSync_q;
    logic [SYNC_STAGES-1:0]      rsSync_q;
    logic [SYNC_STAGES-1:0][7:0] dataSync_q;
    logic                        eLast_q;
    logic                        rsLast_q;
    logic [7:0]                  dataLast_q;
    logic                        fall;

    logic                        xfer_q;
    logic                        xferRs_q;
    logic [7:0]                  xferData_q;

    state_t                      state_q;
    logic [4:0]                  clrCnt_q;
    logic [4:0]                  cursor_q, cursor_d;
    logic                        id_q, id_d;
    logic                        displayOn_q, displayOn_d;
    logic [3:0]                  dispShift_q, dispShift_d;
    logic [7:0]                  cmdCode_q, cmdCode_d;
    logic                        cmdValid_q, cmdValid_d;
    logic                        charValid_q, charValid_d;
    logic                        overrun_q, overrun_d;
    logic                        startClear_d;
    logic                        charWe_d;

    logic [7:0]                  ram_q [32];
    logic [7:0]                  rdData_q;

    // Bring rs/e/data into the clock domain and keep one extra cycle of history
    // so the bus value seen just before the enable fell can be captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eSync_q    <= '0;
            rsSync_q   <= '0;
            dataSync_q <= '0;
            eLast_q    <= 1'b0;
            rsLast_q   <= 1'b0;
            dataLast_q <= '0;
        end else begin
            eSync_q    <= {eSync_q[SYNC_STAGES-2:0], e};
            rsSync_q   <= {rsSync_q[SYNC_STAGES-2:0], rs};
            dataSync_q <= {dataSync_q[SYNC_STAGES-2:0], data};
            eLast_q    <= eSync_q[SYNC_STAGES-1];
            rsLast_q   <= rsSync_q[SYNC_STAGES-1];
            dataLast_q <= dataSync_q[SYNC_STAGES-1];
        end
    end

    assign fall = eLast_q & ~eSync_q[SYNC_STAGES-1];

    // Latch one complete transfer per falling enable edge for the decoder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_q     <= 1'b0;
            xferRs_q   <= 1'b0;
            xferData_q <= '0;
        end else begin
            xfer_q     <= fall;
            xferRs_q   <= rsLast_q;
            xferData_q <= dataLast_q;
        end
    end

    // Decode the captured transfer into next-state values; anything arriving
    // while the clear engine runs is discarded and flagged as an overrun.
    always_comb begin
        cursor_d     = cursor_q;
        id_d         = id_q;
        displayOn_d  = displayOn_q;
        dispShift_d  = dispShift_q;
        cmdCode_d    = cmdCode_q;
        cmdValid_d   = 1'b0;
        charValid_d  = 1'b0;
        overrun_d    = overrun_q;
        startClear_d = 1'b0;
        charWe_d     = 1'b0;
        if (xfer_q) begin
            if (state_q == ST_CLEAR) begin
                overrun_d = 1'b1;
            end else if (xferRs_q) begin
                charWe_d    = 1'b1;
                charValid_d = 1'b1;
                cursor_d    = cursor_q + (id_q ? 5'd1 : 5'd31);
            end else begin
                cmdValid_d = 1'b1;
                cmdCode_d  = xferData_q;
                casez (xferData_q)
                    8'b1???????: cursor_d = {xferData_q[6], xferData_q[3:0]};
                    8'b01??????, 8'b001?????: ;
                    8'b0001????: begin
`ifdef LCD_SHIFT_EN
                        if (xferData_q[3]) begin
                            dispShift_d = xferData_q[2] ? dispShift_q + 4'd1 : dispShift_q - 4'd1;
                        end else begin
                            cursor_d = xferData_q[2] ? cursor_q + 5'd1 : cursor_q - 5'd1;
                        end
`endif
                    end
                    8'b00001???: displayOn_d = xferData_q[2];
                    8'b000001??: id_d = xferData_q[1];
                    8'b0000001?: begin
                        cursor_d = '0;
`ifdef LCD_SHIFT_EN
                        dispShift_d = '0;
`endif
                    end
                    8'b00000001: begin
                        cursor_d     = '0;
                        id_d         = 1'b1;
                        startClear_d = 1'b1;
`ifdef LCD_SHIFT_EN
                        dispShift_d = '0;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    // Clear-engine FSM plus all registered control outputs; reset parks the
    // FSM in CLEAR so the RAM is blanked as soon as reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clrCnt_q    <= '0;
            cursor_q    <= '0;
            id_q        <= 1'b1;
            displayOn_q <= 1'b0;
            dispShift_q <= '0;
            cmdCode_q   <= '0;
            cmdValid_q  <= 1'b0;
            charValid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (startClear_d) begin
                        state_q  <= ST_CLEAR;
                        clrCnt_q <= '0;
                    end
                end
                ST_CLEAR: begin
                    clrCnt_q <= clrCnt_q + 5'd1;
                    if (clrCnt_q == 5'd31) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            cursor_q    <= cursor_d;
            id_q        <= id_d;
            displayOn_q <= displayOn_d;
            dispShift_q <= dispShift_d;
            cmdCode_q   <= cmdCode_d;
            cmdValid_q  <= cmdValid_d;
            charValid_q <= charValid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Display RAM write port: the clear engine owns it while running,
    // otherwise accepted characters land at the current cursor.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            ram_q[clrCnt_q] <= BLANK_CHAR;
        end else if (charWe_d) begin
            ram_q[cursor_q] <= xferData_q;
        end
    end

    // Registered readback; a same-cycle write to the same index returns the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdData_q <= '0;
        end else begin
            rdData_q <= ram_q[rd_addr];
        end
    end

    assign rd_data    = rdData_q;
    assign cursor     = cursor_q;
    assign display_on = displayOn_q;
    assign busy       = (state_q == ST_CLEAR);
    assign cmd_valid  = cmdValid_q;
    assign cmd_code   = cmdCode_q;
    assign char_valid = charValid_q;
    assign overrun    = overrun_q;
    assign disp_shift = dispShift_q;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// tb_lcd_bus_decoder: directed and randomized bus transfers checked against a
// behavioural display model (cursor arithmetic, RAM image, pulse counts).
module tb_lcd_bus_decoder;

    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rs;
    logic       e;
    logic [7:0] data;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [4:0] cursor;
    logic       display_on;
    logic       busy;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic       char_valid;
    logic       overrun;
    logic [3:0] disp_shift;

    lcd_bus_decoder #(.SYNC_STAGES(SYNC_STAGES), .BLANK_CHAR(8'h20)) dut (
        .clk(clk), .rst(rst), .rs(rs), .e(e), .data(data), .rd_addr(rd_addr),
        .rd_data(rd_data), .cursor(cursor), .display_on(display_on), .busy(busy),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .char_valid(char_valid),
        .overrun(overrun), .disp_shift(disp_shift)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cmdPulses = 0;
    int charPulses = 0;
    int busyCycles = 0;

    // Behavioural model of the visible display state.
    logic [7:0] mRam [32];
    int         mCursor, mId, mDisp, mShift, mOverrun, mCode, mCmdCnt, mCharCnt;

    // Count output pulses and busy cycles away from the active edge.
    always @(negedge clk) begin
        if (cmd_valid) cmdPulses++;
        if (char_valid) charPulses++;
        if (busy) busyCycles++;
    end

    // Hard stop if something hangs.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mRam[i] = 8'h20;
        mCursor = 0; mId = 1; mDisp = 0; mShift = 0; mOverrun = 0;
        mCode = 0; mCmdCnt = 0; mCharCnt = 0;
    endtask

    // Apply one accepted transfer to the model using the command table rules.
    task automatic modelApply(input logic r, input logic [7:0] d);
        int msb;
        msb = -1;
        for (int i = 0; i < 8; i++) if (d[i]) msb = i;
        if (r) begin
            mRam[mCursor] = d;
            mCharCnt++;
            mCursor = (mId != 0) ? (mCursor + 1) % 32 : (mCursor + 31) % 32;
        end else begin
            mCmdCnt++;
            mCode = int'(d);
            case (msb)
                7: mCursor = (d[6] ? 16 : 0) + int'(d[3:0]);
                4: begin
`ifdef LCD_SHIFT_EN
                    if (d[3]) mShift = d[2] ? (mShift + 1) % 16 : (mShift + 15) % 16;
                    else mCursor = d[2] ? (mCursor + 1) % 32 : (mCursor + 31) % 32;
`endif
                end
                3: mDisp = int'(d[2]);
                2: mId = int'(d[1]);
                1: begin
                    mCursor = 0;
`ifdef LCD_SHIFT_EN
                    mShift = 0;
`endif
                end
                0: begin
                    mCursor = 0;
                    mId = 1;
                    mShift = 0;
                    for (int i = 0; i < 32; i++) mRam[i] = 8'h20;
                end
                default: ;
            endcase
        end
    endtask

    // Drive one bus write and measure how many negedges after the enable fall the pulse shows.
    task automatic applyStimulus(input logic r, input logic [7:0] d, input bit expectAccept);
        int lat;
        lat = 0;
        @(negedge clk);
        rs = r; data = d; e = 1'b1;
        repeat (3) @(negedge clk);
        e = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (lat == 0 && (cmd_valid || char_valid)) lat = n;
        end
        // Pulse rises on the edge SYNC_STAGES+1 after the first low sample, seen at the next negedge.
        if (expectAccept) checkOutput("latency", lat, SYNC_STAGES + 2);
        else checkOutput("dropNoPulse", lat, 0);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("busyTimeout", 1, 0);
    endtask

    task automatic compareModel();
        checkOutput("cursor", cursor, mCursor);
        checkOutput("displayOn", display_on, mDisp);
        checkOutput("dispShift", disp_shift, mShift);
        checkOutput("cmdCode", cmd_code, mCode);
        checkOutput("overrun", overrun, mOverrun);
        checkOutput("cmdPulses", cmdPulses, mCmdCnt);
        checkOutput("charPulses", charPulses, mCharCnt);
    endtask

    task automatic readOne(input int a, output logic [7:0] v);
        @(negedge clk);
        rd_addr = 5'(a);
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic checkRam();
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            readOne(i, v);
            checkOutput($sformatf("ram[%0d]", i), v, mRam[i]);
        end
    endtask

    initial begin
        int n;
        int busyBefore;
        logic [7:0] v;
        logic [7:0] d;
        logic r;
        int kind;

        rst = 1'b1; rs = 1'b0; e = 1'b0; data = '0; rd_addr = '0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", busy, 1);
        checkOutput("rstCursor", cursor, 0);
        checkOutput("rstDisplayOn", display_on, 0);
        checkOutput("rstCmdCode", cmd_code, 0);
        checkOutput("rstCmdValid", cmd_valid, 0);
        checkOutput("rstCharValid", char_valid, 0);
        checkOutput("rstOverrun", overrun, 0);
        checkOutput("rstDispShift", disp_shift, 0);
        checkOutput("rstRdData", rd_data, 0);

        rst = 1'b0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                n = i;
                break;
            end
        end
        checkOutput("initClearCycles", n, 32);
        checkRam();
        compareModel();

        // Set DDRAM to line 1 column 5, then write 'A'.
        applyStimulus(1'b0, 8'hC5, 1'b1); modelApply(1'b0, 8'hC5); compareModel();
        checkOutput("cursorC5", cursor, 21);
        applyStimulus(1'b1, 8'h41, 1'b1); modelApply(1'b1, 8'h41); compareModel();
        checkOutput("cursorAfterA", cursor, 22);
        readOne(21, v);
        checkOutput("ram21", v, 8'h41);

        // Wrap forward from 31 and backward from 0.
        applyStimulus(1'b0, 8'hCF, 1'b1); modelApply(1'b0, 8'hCF);
        applyStimulus(1'b1, 8'h5A, 1'b1); modelApply(1'b1, 8'h5A); compareModel();
        checkOutput("wrap31to0", cursor, 0);
        applyStimulus(1'b0, 8'h04, 1'b1); modelApply(1'b0, 8'h04);
        applyStimulus(1'b1, 8'h33, 1'b1); modelApply(1'b1, 8'h33); compareModel();
        checkOutput("wrap0to31", cursor, 31);
        applyStimulus(1'b0, 8'h06, 1'b1); modelApply(1'b0, 8'h06);

        // Display on/off.
        applyStimulus(1'b0, 8'h0C, 1'b1); modelApply(1'b0, 8'h0C); compareModel();
        checkOutput("dispOn", display_on, 1);
        checkOutput("code0C", cmd_code, 8'h0C);
        applyStimulus(1'b0, 8'h08, 1'b1); modelApply(1'b0, 8'h08); compareModel();
        checkOutput("dispOff", display_on, 0);

        // Display shift 17 times right, then cursor shift across the line boundary.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b0, 8'h1C, 1'b1); modelApply(1'b0, 8'h1C);
        end
        compareModel();
`ifdef LCD_SHIFT_EN
        checkOutput("shift17", disp_shift, 1);
`else
        checkOutput("shiftTied", disp_shift, 0);
`endif
        applyStimulus(1'b0, 8'h8F, 1'b1); modelApply(1'b0, 8'h8F);
        applyStimulus(1'b0, 8'h14, 1'b1); modelApply(1'b0, 8'h14); compareModel();
`ifdef LCD_SHIFT_EN
        checkOutput("cursorShift", cursor, 16);
`else
        checkOutput("cursorNoShift", cursor, 15);
`endif

        // Randomized traffic across all command classes and characters.
        for (int it = 0; it < 80; it++) begin
            kind = $urandom_range(0, 9);
            r = 1'b0;
            d = 8'($urandom);
            case (kind)
                0, 1, 2, 3, 4: r = 1'b1;
                5: d = {1'b1, d[6:0]};
                6: d = {6'b000001, d[1:0]};
                7: d = {5'b00001, d[2:0]};
                8: d = {4'b0001, d[3:0]};
                default: begin
                    case ($urandom_range(0, 4))
                        0: d = 8'h00;
                        1: d = {7'b0000001, d[0]};
                        2: d = 8'h01;
                        3: d = {3'b001, d[4:0]};
                        default: d = {2'b01, d[5:0]};
                    endcase
                end
            endcase
            applyStimulus(r, d, 1'b1);
            modelApply(r, d);
            if (!r && d == 8'h01) waitIdle();
            compareModel();
            if (it % 20 == 19) checkRam();
        end

        // Clear followed by a character while the clear engine is running.
        busyBefore = busyCycles;
        applyStimulus(1'b0, 8'h01, 1'b1); modelApply(1'b0, 8'h01);
        applyStimulus(1'b1, 8'h7E, 1'b0);
        mOverrun = 1;
        waitIdle();
        checkOutput("clearBusyCycles", busyCycles - busyBefore, 32);
        checkOutput("overrunSet", overrun, 1);
        compareModel();
        checkRam();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
